// File: rtl/posit_to_int_pipe.sv
// rtl/posit_to_int_pipe.sv - three-stage posit to signed integer converter
// Truncates toward zero, saturates on overflow, flags NaR.
module posit_to_int_pipe #(
   parameter int N  = 16,
   parameter int ES = 1,
   parameter int W  = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_posit,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_int,
   output logic         out_sat,
   output logic         out_nar
);

   localparam int SW = $clog2(N) + ES + 2;

   logic advance;
   assign advance  = ~out_valid | out_ready;
   assign in_ready = advance;

   // S1: sign, magnitude (top bit dropped, it is zero except for NaR), specials
   logic         v1, s1, zero1, nar1;
   logic [N-2:0] a1;

   always_ff @(posedge clk) begin
      if (rst) begin
         v1    <= 1'b0;
         s1    <= 1'b0;
         zero1 <= 1'b0;
         nar1  <= 1'b0;
         a1    <= '0;
      end else if (advance) begin
         v1    <= in_valid;
         s1    <= in_posit[N-1];
         zero1 <= (in_posit == '0);
         nar1  <= (in_posit == {1'b1, {(N-1){1'b0}}});
         a1    <= in_posit[N-1] ? (N-1)'(-in_posit) : in_posit[N-2:0];
      end
   end

   // S2: regime run length, exponent and left-aligned fraction
   logic                 lead, done;
   logic [N-2:0]         rem, frac_c;
   logic signed [SW-1:0] scale_c;
   int                   m, k, e;

   always_comb begin
      lead = a1[N-2];
      m    = 0;
      done = 1'b0;
      for (int i = N - 2; i >= 0; i--) begin
         if (!done && (a1[i] == lead)) m = m + 1;
         else done = 1'b1;
      end
      k   = lead ? m - 1 : -m;
      rem = a1 << (m + 1);
      e   = 0;
      for (int j = 0; j < ES; j++) e = (e << 1) | int'(rem[N-2-j]);
      frac_c  = rem << ES;
      scale_c = SW'(k * (2 ** ES) + e);
   end

   logic                 v2, s2, zero2, nar2;
   logic signed [SW-1:0] scale2;
   logic [N-2:0]         f2;

   always_ff @(posedge clk) begin
      if (rst) begin
         v2     <= 1'b0;
         s2     <= 1'b0;
         zero2  <= 1'b0;
         nar2   <= 1'b0;
         scale2 <= '0;
         f2     <= '0;
      end else if (advance) begin
         v2     <= v1;
         s2     <= s1;
         zero2  <= zero1;
         nar2   <= nar1;
         scale2 <= scale_c;
         f2     <= frac_c;
      end
   end

   // S3: {1,f} carries N-1 fraction bits, so shift by scale then drop them
   int           sc;
   logic [W-1:0] mag, res_c;
   logic         sat_c, nar_c;

   always_comb begin
      sc    = int'(scale2);
      mag   = W'(({{W{1'b0}}, 1'b1, f2} << sc) >> (N - 1));
      res_c = '0;
      sat_c = 1'b0;
      nar_c = 1'b0;
      if (nar2) begin
         res_c = {1'b1, {(W-1){1'b0}}};
         nar_c = 1'b1;
      end else if (zero2 || sc < 0) begin
         res_c = '0;
      end else if (sc >= W - 1) begin
         sat_c = 1'b1;
         res_c = s2 ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      end else begin
         res_c = s2 ? -mag : mag;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_int   <= '0;
         out_sat   <= 1'b0;
         out_nar   <= 1'b0;
      end else if (advance) begin
         out_valid <= v2;
         out_int   <= res_c;
         out_sat   <= sat_c;
         out_nar   <= nar_c;
      end
   end

endmodule
